// File: rtl/fpnew_classify_arbiter_pkg.sv
// Shared types and helpers for the FCLASS arbiter slice.
// Contents:
//   fp_format_e        supported floating-point formats
//   exp_bits/man_bits  field widths per format
//   fp_width           total operand width per format
//   fp_info_t          classifier output flags
//   classmask_t        RISC-V FCLASS 10-bit result mask
//   CLS_*              FCLASS bit positions
//   fp_info_to_class   classifier flags + sign -> one-hot FCLASS mask
package fpnew_classify_arbiter_pkg;

    typedef enum logic [2:0] {
        FP32    = 3'd0,
        FP64    = 3'd1,
        FP16    = 3'd2,
        FP8     = 3'd3,
        FP16ALT = 3'd4
    } fp_format_e;

    function automatic int unsigned exp_bits(fp_format_e fmt);
        case (fmt)
            FP64:    return 11;
            FP16:    return 5;
            FP8:     return 5;
            default: return 8;
        endcase
    endfunction

    function automatic int unsigned man_bits(fp_format_e fmt);
        case (fmt)
            FP64:    return 52;
            FP16:    return 10;
            FP8:     return 2;
            FP16ALT: return 7;
            default: return 23;
        endcase
    endfunction

    function automatic int unsigned fp_width(fp_format_e fmt);
        return 1 + exp_bits(fmt) + man_bits(fmt);
    endfunction

    typedef struct packed {
        logic is_normal;
        logic is_subnormal;
        logic is_zero;
        logic is_inf;
        logic is_nan;
        logic is_signalling;
        logic is_quiet;
        logic is_boxed;
    } fp_info_t;

    typedef logic [9:0] classmask_t;

    localparam int unsigned CLS_NEG_INF  = 0;
    localparam int unsigned CLS_NEG_NORM = 1;
    localparam int unsigned CLS_NEG_SUB  = 2;
    localparam int unsigned CLS_NEG_ZERO = 3;
    localparam int unsigned CLS_POS_ZERO = 4;
    localparam int unsigned CLS_POS_SUB  = 5;
    localparam int unsigned CLS_POS_NORM = 6;
    localparam int unsigned CLS_POS_INF  = 7;
    localparam int unsigned CLS_SNAN     = 8;
    localparam int unsigned CLS_QNAN     = 9;

    // NaN is tested first so an unboxed operand (flagged as quiet NaN by the
    // classifier) maps to the quiet-NaN bit whatever its sign bit says.
    function automatic classmask_t fp_info_to_class(fp_info_t info, logic sign);
        classmask_t mask;
        mask = '0;
        if (info.is_nan) begin
            if (info.is_signalling) mask[CLS_SNAN] = 1'b1;
            else                    mask[CLS_QNAN] = 1'b1;
        end else if (info.is_inf) begin
            if (sign) mask[CLS_NEG_INF] = 1'b1;
            else      mask[CLS_POS_INF] = 1'b1;
        end else if (info.is_zero) begin
            if (sign) mask[CLS_NEG_ZERO] = 1'b1;
            else      mask[CLS_POS_ZERO] = 1'b1;
        end else if (info.is_subnormal) begin
            if (sign) mask[CLS_NEG_SUB] = 1'b1;
            else      mask[CLS_POS_SUB] = 1'b1;
        end else begin
            if (sign) mask[CLS_NEG_NORM] = 1'b1;
            else      mask[CLS_POS_NORM] = 1'b1;
        end
        return mask;
    endfunction

endpackage

// File: rtl/fpnew_classify_arbiter_classifier.sv
// Operand classifier (fpnew_classifier interface).
// Ports:
//   operands_i  NumOperands x WIDTH operands
//   is_boxed_i  NaN-boxing flag per operand; unboxed operands read as quiet NaN
//   info_o      classification flags per operand
module fpnew_classifier
    import fpnew_classify_arbiter_pkg::*;
#(
    parameter fp_format_e  FpFormat    = FP32,
    parameter int unsigned NumOperands = 1,
    localparam int unsigned WIDTH      = fp_width(FpFormat)
) (
    input  logic     [NumOperands-1:0][WIDTH-1:0] operands_i,
    input  logic     [NumOperands-1:0]            is_boxed_i,
    output fp_info_t [NumOperands-1:0]            info_o
);

    localparam int unsigned EXP_BITS = exp_bits(FpFormat);
    localparam int unsigned MAN_BITS = man_bits(FpFormat);

    for (genvar i = 0; i < NumOperands; i++) begin : gen_op
        logic [EXP_BITS-1:0] exponent;
        logic [MAN_BITS-1:0] mantissa;
        logic                boxed;
        logic                exp_max;
        logic                nan_pattern;

        always_comb begin
            exponent    = operands_i[i][WIDTH-2 -: EXP_BITS];
            mantissa    = operands_i[i][MAN_BITS-1:0];
            boxed       = is_boxed_i[i];
            exp_max     = (exponent == '1);
            nan_pattern = exp_max && (mantissa != '0);

            info_o[i].is_normal     = boxed && (exponent != '0) && !exp_max;
            info_o[i].is_subnormal  = boxed && (exponent == '0) && (mantissa != '0);
            info_o[i].is_zero       = boxed && (exponent == '0) && (mantissa == '0);
            info_o[i].is_inf        = boxed && exp_max && (mantissa == '0);
            info_o[i].is_nan        = !boxed || nan_pattern;
            info_o[i].is_signalling = boxed && nan_pattern && !mantissa[MAN_BITS-1];
            info_o[i].is_quiet      = (!boxed || nan_pattern) &&
                                      !(boxed && nan_pattern && !mantissa[MAN_BITS-1]);
            info_o[i].is_boxed      = boxed;
        end
    end

endmodule

// File: rtl/fpnew_classify_arbiter_rr.sv
// Round-robin arbiter with internal pointer.
// Ports:
//   clk, rst     clock and asynchronous active-high reset
//   req          request vector
//   enable       grants are only issued while high
//   grant        one-hot grant (all zero when nothing granted)
//   index        index of the granted requester
//   grant_valid  a grant is issued this cycle
// The pointer moves to one past the winner after a grant and holds otherwise.
module fpnew_rr_arbiter #(
    parameter int unsigned  NumReq = 4,
    localparam int unsigned IdxW   = $clog2(NumReq)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NumReq-1:0] req,
    input  logic              enable,
    output logic [NumReq-1:0] grant,
    output logic [IdxW-1:0]   index,
    output logic              grant_valid
);

    logic [IdxW-1:0] ptr;
    int unsigned     slot;

    always_comb begin
        grant       = '0;
        index       = '0;
        grant_valid = 1'b0;
        slot        = 0;
        for (int unsigned k = 0; k < NumReq; k++) begin
            slot = 32'(ptr) + k;
            if (slot >= NumReq) slot = slot - NumReq;
            if (enable && !grant_valid && req[slot]) begin
                grant[slot] = 1'b1;
                index       = IdxW'(slot);
                grant_valid = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (grant_valid) begin
            ptr <= (index == IdxW'(NumReq - 1)) ? '0 : index + 1'b1;
        end
    end

endmodule

// File: rtl/fpnew_classify_arbiter.sv
// Shares one FCLASS classifier among NumReq requesters with round-robin
// arbitration and a registered result stage.
// Ports:
//   clk_i, rst_i     clock, asynchronous active-high reset
//   req_valid_i      request valid per requester
//   req_ready_o      one-hot accept, per requester
//   req_operand_i    operand per requester
//   req_is_boxed_i   NaN-boxing flag per requester
//   req_tag_i        opaque tag per requester
//   flush_i          kill in-flight result(s), no grant this cycle
//   out_valid_o      result valid
//   out_ready_i      downstream accepts the result
//   out_class_o      one-hot FCLASS mask
//   out_tag_o        tag of the classified request
//   out_req_id_o     index of the granted requester
//   busy_o           result valid or any request pending
// Build option: FPNEW_CLASSIFY_SKID_EN adds a 2-entry skid buffer behind the
// result register so req_ready_o no longer depends on out_ready_i.
module fpnew_classify_arbiter
    import fpnew_classify_arbiter_pkg::*;
#(
    parameter fp_format_e   FpFormat = FP32,
    parameter int unsigned  NumReq   = 4,
    parameter int unsigned  TagWidth = 4,
    localparam int unsigned WIDTH    = fp_width(FpFormat),
    localparam int unsigned IdxW     = $clog2(NumReq)
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic [NumReq-1:0]                 req_valid_i,
    output logic [NumReq-1:0]                 req_ready_o,
    input  logic [NumReq-1:0][WIDTH-1:0]      req_operand_i,
    input  logic [NumReq-1:0]                 req_is_boxed_i,
    input  logic [NumReq-1:0][TagWidth-1:0]   req_tag_i,
    input  logic                              flush_i,
    output logic                              out_valid_o,
    input  logic                              out_ready_i,
    output classmask_t                        out_class_o,
    output logic [TagWidth-1:0]               out_tag_o,
    output logic [IdxW-1:0]                   out_req_id_o,
    output logic                              busy_o
);

    logic                 free;
    logic                 enable;
    logic                 grant_valid;
    logic [IdxW-1:0]      grant_idx;
    logic [0:0][WIDTH-1:0] sel_operand;
    logic                 sel_boxed;
    logic [TagWidth-1:0]  sel_tag;
    fp_info_t [0:0]       info;
    classmask_t           sel_class;

    // Holding off grants during reset keeps every ready low while rst_i is high.
    assign enable = free && !flush_i && !rst_i;

    fpnew_rr_arbiter #(.NumReq(NumReq)) u_arb (
        .clk         (clk_i),
        .rst         (rst_i),
        .req         (req_valid_i),
        .enable      (enable),
        .grant       (req_ready_o),
        .index       (grant_idx),
        .grant_valid (grant_valid)
    );

    always_comb begin
        sel_operand[0] = req_operand_i[grant_idx];
        sel_boxed      = req_is_boxed_i[grant_idx];
        sel_tag        = req_tag_i[grant_idx];
    end

    fpnew_classifier #(.FpFormat(FpFormat), .NumOperands(1)) u_cls (
        .operands_i (sel_operand),
        .is_boxed_i (sel_boxed),
        .info_o     (info)
    );

    assign sel_class = fp_info_to_class(info[0], sel_operand[0][WIDTH-1]);
    assign busy_o    = out_valid_o || (|req_valid_i);

`ifdef FPNEW_CLASSIFY_SKID_EN
    typedef struct packed {
        classmask_t          cls;
        logic [TagWidth-1:0] tag;
        logic [IdxW-1:0]     id;
    } entry_t;

    // Entry 0 is the result register, entries 1..2 form the skid buffer;
    // together a 3-deep FIFO whose head drives the outputs.
    entry_t     entries [3];
    logic [1:0] count;
    logic       pop;
    logic [1:0] wr_slot;

    assign free = (count != 2'd3);

    always_comb begin
        pop     = (count != 2'd0) && out_ready_i;
        wr_slot = count - {1'b0, pop};
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count   <= 2'd0;
            entries <= '{default: '0};
        end else if (flush_i) begin
            count <= 2'd0;
        end else begin
            if (pop) begin
                for (int unsigned k = 0; k < 2; k++) entries[k] <= entries[k+1];
            end
            // Placed after the shift so a same-edge push wins the shared slot.
            if (grant_valid) entries[wr_slot] <= '{cls: sel_class, tag: sel_tag, id: grant_idx};
            count <= count - {1'b0, pop} + {1'b0, grant_valid};
        end
    end

    assign out_valid_o  = (count != 2'd0);
    assign out_class_o  = entries[0].cls;
    assign out_tag_o    = entries[0].tag;
    assign out_req_id_o = entries[0].id;
`else
    assign free = !out_valid_o || out_ready_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            out_valid_o  <= 1'b0;
            out_class_o  <= '0;
            out_tag_o    <= '0;
            out_req_id_o <= '0;
        end else if (flush_i) begin
            out_valid_o <= 1'b0;
        end else if (grant_valid) begin
            out_valid_o  <= 1'b1;
            out_class_o  <= sel_class;
            out_tag_o    <= sel_tag;
            out_req_id_o <= grant_idx;
        end else if (out_ready_i) begin
            out_valid_o <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_fpnew_classify_arbiter.sv
// Scoreboard bench for fpnew_classify_arbiter (FP32, 4 requesters, 4-bit tags).
// A reference model predicts grants from the round-robin rule and pushes the
// expected {class, tag, id} per accepted request; a monitor compares the DUT
// output against the queue head every cycle.
module tb_fpnew_classify_arbiter;
    import fpnew_classify_arbiter_pkg::*;

    localparam int NR = 4;
    localparam int TW = 4;
    localparam int W  = 32;
`ifdef FPNEW_CLASSIFY_SKID_EN
    localparam int CAPACITY = 3;
`else
    localparam int CAPACITY = 1;
`endif

    logic                    clk = 1'b0;
    logic                    rst;
    logic [NR-1:0]           req_valid;
    logic [NR-1:0]           req_ready;
    logic [NR-1:0][W-1:0]    req_op;
    logic [NR-1:0]           req_boxed;
    logic [NR-1:0][TW-1:0]   req_tag;
    logic                    flush;
    logic                    out_valid;
    logic                    out_ready;
    classmask_t              out_class;
    logic [TW-1:0]           out_tag;
    logic [1:0]              out_id;
    logic                    busy;

    fpnew_classify_arbiter #(.FpFormat(FP32), .NumReq(NR), .TagWidth(TW)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .req_valid_i    (req_valid),
        .req_ready_o    (req_ready),
        .req_operand_i  (req_op),
        .req_is_boxed_i (req_boxed),
        .req_tag_i      (req_tag),
        .flush_i        (flush),
        .out_valid_o    (out_valid),
        .out_ready_i    (out_ready),
        .out_class_o    (out_class),
        .out_tag_o      (out_tag),
        .out_req_id_o   (out_id),
        .busy_o         (busy)
    );

    always #5 clk = ~clk;

    int unsigned   n_checks = 0;
    int unsigned   n_fail   = 0;
    logic [15:0]   sb [$];
    int            occ = 0;
    int            ptr = 0;
    logic [NR-1:0] mdl_gnt = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // FCLASS from the IEEE-754 single-precision field rules.
    function automatic logic [9:0] ref_class(input logic [31:0] v, input logic boxed);
        int  e;
        int  m;
        bit  s;
        e = int'(v[30:23]);
        m = int'(v[22:0]);
        s = v[31];
        if (!boxed) return 10'h200;
        if (e == 255) begin
            if (m == 0) return s ? 10'h001 : 10'h080;
            return (m >= 32'h400000) ? 10'h200 : 10'h100;
        end
        if (e == 0) begin
            if (m == 0) return s ? 10'h008 : 10'h010;
            return s ? 10'h004 : 10'h020;
        end
        return s ? 10'h002 : 10'h040;
    endfunction

    function automatic logic [31:0] rand_op();
        logic [31:0] v;
        logic        s;
        s = 1'($urandom_range(1));
        case ($urandom_range(7))
            0:       v = {s, 31'h0};
            1:       v = {s, 8'h00, 23'($urandom) | 23'd1};
            2:       v = {s, 8'hFF, 23'h0};
            3:       v = {s, 8'hFF, 1'b0, 22'($urandom) | 22'd1};
            4:       v = {s, 8'hFF, 1'b1, 22'($urandom)};
            default: v = $urandom;
        endcase
        return v;
    endfunction

    // Monitor: output valid must track scoreboard occupancy; head must match.
    initial forever begin
        @(negedge clk);
        if (rst) begin
            check("out_valid_in_reset", 32'(out_valid), 32'd0);
            check("out_fields_in_reset", 32'({out_class, out_tag, out_id}), 32'd0);
        end else begin
            check("out_valid", 32'(out_valid), 32'(sb.size() != 0));
            if (sb.size() != 0) begin
                check("out_result{class,tag,id}", 32'({out_class, out_tag, out_id}), 32'(sb[0]));
                if (out_ready && !flush) void'(sb.pop_front());
            end
        end
    end

    // Reference model: grant prediction, busy, and expected-result pushes.
    initial forever begin
        logic [NR-1:0] exp_rdy;
        bit            free;
        int            g;
        int            j;
        @(negedge clk);
        #2;
        exp_rdy = '0;
        g       = -1;
        if (rst) begin
            check("busy", 32'(busy), 32'(|req_valid));
            occ = 0;
            ptr = 0;
            sb.delete();
        end else begin
            check("busy", 32'(busy), 32'((occ != 0) || (|req_valid)));
            free = (CAPACITY > 1) ? (occ < CAPACITY) : ((occ == 0) || out_ready);
            if (free && !flush) begin
                for (int k = 0; k < NR; k++) begin
                    j = (ptr + k) % NR;
                    if (g < 0 && req_valid[j]) begin
                        exp_rdy[j] = 1'b1;
                        g = j;
                    end
                end
            end
        end
        check("req_ready", 32'(req_ready), 32'(exp_rdy));
        if (!rst) begin
            if (flush) begin
                sb.delete();
                occ = 0;
            end else begin
                if (occ > 0 && out_ready) occ--;
                if (g >= 0) begin
                    sb.push_back({ref_class(req_op[g], req_boxed[g]), req_tag[g], 2'(g)});
                    occ++;
                    ptr = (g + 1) % NR;
                end
            end
        end
        mdl_gnt = exp_rdy;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input int r, input logic [31:0] op, input logic boxed, input logic [3:0] tag);
        bit done;
        done         = 1'b0;
        req_valid[r] = 1'b1;
        req_op[r]    = op;
        req_boxed[r] = boxed;
        req_tag[r]   = tag;
        for (int k = 0; k < 16 && !done; k++) begin
            tick();
            if (mdl_gnt[r]) done = 1'b1;
        end
        req_valid[r] = 1'b0;
        n_checks++;
        if (!done) begin
            n_fail++;
            $display("FAIL issue_timeout: requester %0d not granted within 16 cycles, required grant", r);
        end
    endtask

    // Requesters hold operand/tag while waiting; new values only after a grant
    // or while idle. pd = chance of dropping a waiting request.
    task automatic run_random(input int cycles, input int pv, input int pr, input int pf, input int pd);
        for (int c = 0; c < cycles; c++) begin
            for (int r = 0; r < NR; r++) begin
                if (req_valid[r] && !mdl_gnt[r]) begin
                    if ($urandom_range(99) < pd) req_valid[r] = 1'b0;
                end else begin
                    req_valid[r] = ($urandom_range(99) < pv);
                    if (req_valid[r]) begin
                        req_op[r]    = rand_op();
                        req_boxed[r] = ($urandom_range(9) != 0);
                        req_tag[r]   = 4'($urandom);
                    end
                end
            end
            out_ready = ($urandom_range(99) < pr);
            flush     = ($urandom_range(99) < pf);
            tick();
        end
        flush = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_op    = '0;
        req_boxed = '0;
        req_tag   = '0;
        flush     = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        tick();

        issue(0, 32'hFF800000, 1'b1, 4'h5);
        tick();
        tick();

        issue(1, 32'h00000000, 1'b1, 4'h1);
        issue(1, 32'h80000001, 1'b1, 4'h2);
        issue(1, 32'h7F800001, 1'b1, 4'h3);
        issue(1, 32'h7FC00000, 1'b1, 4'h4);
        tick();
        tick();

        issue(2, 32'h3F800000, 1'b0, 4'h9);
        tick();
        tick();

        // All four contending with downstream always ready.
        run_random(12, 100, 100, 0, 0);
        // Backpressure with requests held.
        run_random(6, 100, 0, 0, 0);
        // Flush while a result is pending and requests are waiting.
        run_random(1, 100, 0, 100, 0);
        run_random(3, 100, 100, 0, 0);
        // Reset in the middle of traffic with a result pending.
        run_random(3, 100, 0, 0, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        run_random(4, 100, 100, 0, 0);

        run_random(400, 60, 70, 2, 20);

        req_valid = '0;
        out_ready = 1'b1;
        flush     = 1'b0;
        repeat (6) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
